// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if -- requester-side bus of the ROM arbiter.
//
// Carries both read ports:
//   req0/req1   level read request, held until the matching ack
//   addr0/addr1 ROM address, stable while its req is high
//   ack0/ack1   one-cycle pulse, rdata valid in that cycle
//   rdata0/1    read data, held until the next ack of that port
//
// Modports: master = requester side, slave = arbiter side.

interface rom_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 8
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic          ack0;
    logic [DW-1:0] rdata0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic          ack1;
    logic [DW-1:0] rdata1;

    modport master (
        output req0, addr0, req1, addr1,
        input  ack0, rdata0, ack1, rdata1
    );

    modport slave (
        input  req0, addr0, req1, addr1,
        output ack0, rdata0, ack1, rdata1
    );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter -- shares one single-port synchronous ROM between the 6502
// fetch path (port 0) and a secondary reader (port 1).
//
// Ports:
//   clk       system clock, posedge
//   reset     synchronous, active-high
//   bus       rom_arbiter_if.slave (req/addr/ack/rdata for ports 0 and 1)
//   busy      high whenever the sequencer is not idle
//   rom_ce    ROM clock enable, high for exactly the issue cycle
//   rom_oce   ROM output-register enable (constant 1 when RD_LAT=1)
//   rom_ad    ROM address, holds the last granted address
//   rom_dout  ROM read data
//
// Parameters: AW, DW, RD_LAT (1 = bypass output, 2 = registered output).
// Option macro ROM_ARB_RR_EN: round-robin on ties instead of fixed
// priority to port 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a request; picks a winner and raises rom_ce
// S_ISSUE | rom_ce high this cycle; arms oce and the latency counter
// S_WAIT  | counting down the ROM latency; captures dout at zero
// S_DONE  | ack high for the winning port; requests ignored

module rom_arbiter #(
    parameter int AW     = 11,
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    rom_arbiter_if.slave  bus,
    output logic          busy,
    output logic          rom_ce,
    output logic          rom_oce,
    output logic [AW-1:0] rom_ad,
    input  logic [DW-1:0] rom_dout
);

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
            $error("rom_arbiter: RD_LAT must be 1 or 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t        r_state;
    logic [1:0]    r_cnt;
    logic          r_sel;
    logic          r_last_grant;
    logic          r_ack0;
    logic          r_ack1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_busy;
    logic          r_ce;
    logic          r_oce;
    logic [AW-1:0] r_ad;

    logic          w_any_req;
    logic          w_win;
    logic [AW-1:0] w_addr;

    assign w_any_req = bus.req0 | bus.req1;

`ifdef ROM_ARB_RR_EN
    // On a tie the port that did not win last time goes next.
    assign w_win = (bus.req0 && bus.req1) ? ~r_last_grant : ~bus.req0;
`else
    // Port 0 always wins when it is asking.
    assign w_win = ~bus.req0;
    logic w_unused_last_grant;
    assign w_unused_last_grant = r_last_grant;
`endif

    assign w_addr = w_win ? bus.addr1 : bus.addr0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_sel        <= 1'b0;
            r_last_grant <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_busy       <= 1'b0;
            r_ce         <= 1'b0;
            r_oce        <= 1'b0;
            r_ad         <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            // Bypass-mode ROM: the output register is never used, keep it open.
            if (RD_LAT == 1) begin
                r_oce <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_sel        <= w_win;
                        r_last_grant <= w_win;
                        r_ad         <= w_addr;
                        r_ce         <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_ce <= 1'b0;
                    if (RD_LAT == 2) begin
                        r_oce <= 1'b1;
                    end
                    r_cnt   <= CNT_INIT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        if (r_sel) begin
                            r_rdata1 <= rom_dout;
                            r_ack1   <= 1'b1;
                        end else begin
                            r_rdata0 <= rom_dout;
                            r_ack0   <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                        if (RD_LAT == 2) begin
                            r_oce <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack0   = r_ack0;
    assign bus.ack1   = r_ack1;
    assign bus.rdata0 = r_rdata0;
    assign bus.rdata1 = r_rdata1;
    assign busy       = r_busy;
    assign rom_ce     = r_ce;
    assign rom_oce    = r_oce;
    assign rom_ad     = r_ad;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter -- self-checking bench for rom_arbiter.
// A transaction-schedule model predicts every output each cycle; directed
// phases pin literal latencies, data and grant orders.

module tb_rom_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rom_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    logic          busy;
    logic          rom_ce;
    logic          rom_oce;
    logic [AW-1:0] rom_ad;
    logic [DW-1:0] rom_dout;

    rom_arbiter #(.AW(AW), .DW(DW), .RD_LAT(L)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .rom_ce   (rom_ce),
        .rom_oce  (rom_oce),
        .rom_ad   (rom_ad),
        .rom_dout (rom_dout)
    );

    // ROM behaviour: ce captures the array, oce loads the output register.
    logic [DW-1:0] rom_mem [0:2047];
    logic [DW-1:0] q_byp;
    logic [DW-1:0] q_reg;
    always @(posedge clk) begin
        if (rom_ce === 1'b1) q_byp <= rom_mem[rom_ad];
        if (rom_oce === 1'b1) q_reg <= q_byp;
    end
    assign rom_dout = (L == 2) ? q_reg : q_byp;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Schedule model: a grant decided in idle cycle T gives ce in T+1,
    // oce in T+2 (L=2), ack and new rdata in T+L+2, idle again in T+L+3.
    bit            m_started = 1'b0;
    bit            m_active  = 1'b0;
    bit            m_win     = 1'b0;
    bit            m_lg      = 1'b1;
    bit            m_oce1    = 1'b0;
    int            m_t       = 0;
    logic [AW-1:0] m_addr    = '0;
    logic [AW-1:0] m_ad      = '0;
    logic [DW-1:0] m_rd0     = '0;
    logic [DW-1:0] m_rd1     = '0;
    bit            last_ack0 = 1'b0;
    bit            last_ack1 = 1'b0;
    bit            log_en    = 1'b0;
    int            log_port[$];
    int            log_cyc[$];

    always @(negedge clk) begin
        bit was_active;
        int done_c;
        done_c     = m_t + L + 2;
        was_active = m_active;
        if (m_active && cyc == done_c) begin
            if (m_win) m_rd1 = rom_mem[m_addr];
            else       m_rd0 = rom_mem[m_addr];
        end
        if (m_started) begin
            check("busy",    busy,     m_active);
            check("rom_ce",  rom_ce,   m_active && cyc == m_t + 1);
            check("rom_oce", rom_oce,  (L == 2) ? (m_active && cyc == m_t + 2) : m_oce1);
            check("ack0",    bus.ack0, m_active && !m_win && cyc == done_c);
            check("ack1",    bus.ack1, m_active && m_win && cyc == done_c);
            check("rdata0",  bus.rdata0, m_rd0);
            check("rdata1",  bus.rdata1, m_rd1);
            check("rom_ad",  rom_ad,   m_ad);
        end
        if (log_en && bus.ack0 === 1'b1) begin log_port.push_back(0); log_cyc.push_back(cyc); end
        if (log_en && bus.ack1 === 1'b1) begin log_port.push_back(1); log_cyc.push_back(cyc); end
        last_ack0 = (bus.ack0 === 1'b1);
        last_ack1 = (bus.ack1 === 1'b1);

        if (reset) begin
            m_started = 1'b1;
            m_active  = 1'b0;
            m_rd0     = '0;
            m_rd1     = '0;
            m_ad      = '0;
            m_lg      = 1'b1;
            m_oce1    = 1'b0;
        end else if (m_started) begin
            m_oce1 = 1'b1;
            if (was_active && cyc == done_c) begin
                m_active = 1'b0;
            end else if (!was_active && (bus.req0 || bus.req1)) begin
`ifdef ROM_ARB_RR_EN
                if (bus.req0 && bus.req1) m_win = (m_lg == 1'b1) ? 1'b0 : 1'b1;
                else                      m_win = bus.req1 && !bus.req0;
`else
                m_win = !bus.req0;
`endif
                m_addr   = m_win ? bus.addr1 : bus.addr0;
                m_ad     = m_addr;
                m_lg     = m_win;
                m_t      = cyc;
                m_active = 1'b1;
            end
        end
    end

    task automatic do_read(input bit p, input logic [AW-1:0] a,
                           output int lat, output logic [DW-1:0] d);
        int t0;
        @(posedge clk); #1;
        if (p) begin bus.req1 = 1'b1; bus.addr1 = a; end
        else   begin bus.req0 = 1'b1; bus.addr0 = a; end
        t0  = cyc;
        lat = -1;
        d   = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((p ? bus.ack1 : bus.ack0) === 1'b1) begin
                lat = cyc - t0;
                d   = p ? bus.rdata1 : bus.rdata0;
                break;
            end
        end
        @(posedge clk); #1;
        if (p) bus.req1 = 1'b0;
        else   bus.req0 = 1'b0;
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int            lat;
        logic [DW-1:0] d;
        int            t0;
        int            exp_seq[6];

        for (int i = 0; i < 2048; i++) rom_mem[i] = DW'($urandom);
        rom_mem[0] = 8'hA9;
        bus.req0 = 1'b0; bus.addr0 = '0;
        bus.req1 = 1'b0; bus.addr1 = '0;

        // Reset for two cycles, then idle.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_busy",   busy, 0);
        check("idle_ce",     rom_ce, 0);
        check("idle_rdata0", bus.rdata0, 0);
        check("idle_rdata1", bus.rdata1, 0);

        // Single read of address 0.
        do_read(1'b0, 11'h000, lat, d);
        check("single_lat",  lat, 4);
        check("single_data", d, 8'hA9);

        // Sequential reads on port 0.
        for (int a = 1; a <= 5; a++) begin
            do_read(1'b0, AW'(a), lat, d);
            check("seq_lat",  lat, L + 2);
            check("seq_data", d, rom_mem[a]);
        end

        // Contention: both held, port 0 drops after three grants.
        pulse_reset(2);
        log_port.delete();
        log_cyc.delete();
        log_en = 1'b1;
        fork
            begin
                int n0;
                n0 = 0;
                @(posedge clk); #1;
                bus.req0 = 1'b1; bus.addr0 = 11'h7FF;
                for (int i = 0; i < 200 && n0 < 3; i++) begin
                    @(negedge clk);
                    if (bus.ack0 === 1'b1) begin
                        if (n0 == 0) check("rdata1_before_ack1", bus.rdata1, 0);
                        check("cont_data0", bus.rdata0, rom_mem[11'h7FF]);
                        n0++;
                    end
                end
                @(posedge clk); #1 bus.req0 = 1'b0;
                check("cont_acks0", n0, 3);
            end
            begin
                int n1;
                n1 = 0;
                @(posedge clk); #1;
                bus.req1 = 1'b1; bus.addr1 = 11'h010;
                for (int i = 0; i < 200 && n1 < 3; i++) begin
                    @(negedge clk);
                    if (bus.ack1 === 1'b1) begin
                        check("cont_data1", bus.rdata1, rom_mem[11'h010]);
                        n1++;
                    end
                end
                @(posedge clk); #1 bus.req1 = 1'b0;
                check("cont_acks1", n1, 3);
            end
        join
        log_en = 1'b0;
`ifdef ROM_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 1, 1, 1};
`endif
        check("grant_count", log_port.size(), 6);
        for (int i = 0; i < 6 && i < log_port.size(); i++) begin
            check("grant_order", log_port[i], exp_seq[i]);
            if (i > 0) check("grant_gap", log_cyc[i] - log_cyc[i-1], L + 3);
        end

        // Reset during the wait phase aborts the access without an ack.
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.addr0 = 11'h123;
        t0 = cyc;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("abort_in_wait_busy", busy, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clk);
        check("abort_ce",   rom_ce, 0);
        check("abort_oce",  rom_oce, 0);
        check("abort_busy", busy, 0);
        check("abort_cyc",  cyc - t0, 3);
        repeat (5) begin
            @(negedge clk);
            check("abort_no_ack", bus.ack0, 0);
        end
        do_read(1'b0, 11'h0AB, lat, d);
        check("post_abort_lat",  lat, L + 2);
        check("post_abort_data", d, rom_mem[11'h0AB]);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 299) == 0);
            if (bus.req0 && last_ack0) bus.req0 = 1'b0;
            else if (!bus.req0 && $urandom_range(0, 3) == 0) begin
                bus.req0 = 1'b1; bus.addr0 = AW'($urandom);
            end
            if (bus.req1 && last_ack1) bus.req1 = 1'b0;
            else if (!bus.req1 && $urandom_range(0, 3) == 0) begin
                bus.req1 = 1'b1; bus.addr1 = AW'($urandom);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
